// File: rtl/program_loader.sv
// Byte-stream program loader: receives a word count then big-endian instruction words and
// writes them into CPU instruction memory while holding the CPU in reset.
module program_loader #(
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        wr_strobe,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StCount, StRecv, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [7:0]          n_q, n_d;
  logic [8:0]          idx_q, idx_d;
  logic [23:0]         asm_q, asm_d;   // first three bytes; the fourth goes straight into data
  logic [1:0]          nbyte_q, nbyte_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         addr_q, addr_d;
  logic                error_q, error_d;
  logic                strobe_q, strobe_d;

  logic       in_range;
  logic [8:0] idx_inc;

  assign in_range = (32'(idx_q) < MAX_WORDS);
  assign idx_inc  = idx_q + 9'd1;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    nbyte_d    = nbyte_q;
    timer_d    = timer_q;
    data_d     = data_q;
    addr_d     = addr_q;
    error_d    = error_q;
    strobe_d   = 1'b0;
    byte_ready = 1'b0;
    initialize = 1'b1;
    cpu_rst    = 1'b1;
    done       = 1'b0;

    case (state_q)
      StCount: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          n_d     = byte_data;
          idx_d   = '0;
          nbyte_d = '0;
          timer_d = '0;
          state_d = (byte_data == 8'd0) ? StDone : StRecv;
        end
      end
      StRecv: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          asm_d   = {asm_q[15:0], byte_data};
          nbyte_d = nbyte_q + 2'd1;
          timer_d = '0;
          if (nbyte_q == 2'd3) begin
            state_d = StWrite;
            // Out-of-range words are still consumed, but never reach the CPU.
            if (in_range) begin
              strobe_d = 1'b1;
              data_d   = {asm_q, byte_data};
              addr_d   = {21'd0, idx_q, 2'b00};
            end else begin
              error_d = 1'b1;
            end
          end
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWrite: begin
        idx_d   = idx_inc;
        timer_d = '0;
        state_d = (idx_inc == {1'b0, n_q}) ? StDone : StRecv;
      end
      StDone: begin
        initialize = 1'b0;
        cpu_rst    = 1'b0;
        done       = 1'b1;
      end
      default: state_d = StCount;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StCount;
      n_q      <= '0;
      idx_q    <= '0;
      asm_q    <= '0;
      nbyte_q  <= '0;
      timer_q  <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      error_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      nbyte_q  <= nbyte_d;
      timer_q  <= timer_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      error_q  <= error_d;
      strobe_q <= strobe_d;
    end
  end

  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign wr_strobe                      = strobe_q;
  assign error                          = error_q;

endmodule
